rv32_bus_arbiter: RTL and testbench

//   Shares one memory port between the core's instruction bus and data bus, so a rv32 core
//   can sit on a single-ported RAM/peripheral fabric. Sits between the core's instr_*/data_*

---
 rtl/rv32_bus_arbiter_if.sv | 46 ++++
 rtl/rv32_bus_arbiter.sv | 120 ++++++++++++
 tb/tb_rv32_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_bus_arbiter_if.sv
// Bundle of core-side (instr/data) and memory-side signals around the shared-port arbiter.
// master = the arbiter itself; slave = the core plus memory environment that surrounds it.
interface rv32_bus_arbiter_if;
    logic [31:0] instr_address_in;
    logic        instr_read_in;
    logic [31:0] instr_read_value_out;
    logic        instr_ready_out;

    logic [31:0] data_address_in;
    logic        data_read_in;
    logic        data_write_in;
    logic [3:0]  data_write_mask_in;
    logic [31:0] data_write_value_in;
    logic [31:0] data_read_value_out;
    logic        data_ready_out;

    logic [31:0] mem_address_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic [3:0]  mem_write_mask_out;
    logic [31:0] mem_write_value_out;
    logic [31:0] mem_read_value_in;
    logic        mem_ready_in;

    logic        timeout_out;

    modport master (
        input  instr_address_in, instr_read_in,
        input  data_address_in, data_read_in, data_write_in, data_write_mask_in, data_write_value_in,
        input  mem_read_value_in, mem_ready_in,
        output instr_read_value_out, instr_ready_out,
        output data_read_value_out, data_ready_out,
        output mem_address_out, mem_read_out, mem_write_out, mem_write_mask_out, mem_write_value_out,
        output timeout_out
    );

    modport slave (
        output instr_address_in, instr_read_in,
        output data_address_in, data_read_in, data_write_in, data_write_mask_in, data_write_value_in,
        output mem_read_value_in, mem_ready_in,
        input  instr_read_value_out, instr_ready_out,
        input  data_read_value_out, data_ready_out,
        input  mem_address_out, mem_read_out, mem_write_out, mem_write_mask_out, mem_write_value_out,
        input  timeout_out
    );
endinterface

// File: rtl/rv32_bus_arbiter.sv
// Shares one memory port between the rv32 instruction and data buses.
// Data-first arbitration from IDLE, alternation on completion, optional watchdog.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | no grant; memory port quiet, arbitrating incoming requests
//   ST_INSTR | fetch owns the port; mem_* follow instr_* inputs
//   ST_DATA  | load/store owns the port; mem_* follow data_* inputs
module rv32_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input logic               clk,
    input logic               reset,
    rv32_bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INSTR = 2'd1,
        ST_DATA  = 2'd2
    } state_e;

    localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_SAT  = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES) : '0;
    localparam logic             WD_EN    = (TIMEOUT_CYCLES > 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic data_req;
    logic owner_req;
    logic wd_hit;
    logic done;

    always_comb begin
        data_req  = bus.data_read_in | bus.data_write_in;
        owner_req = 1'b0;
        case (state_q)
            ST_INSTR: owner_req = bus.instr_read_in;
            ST_DATA:  owner_req = data_req;
            default:  owner_req = 1'b0;
        endcase
        // Watchdog fires on the last allowed granted cycle, only while the owner still wants the port.
        wd_hit = WD_EN && (state_q != ST_IDLE) && owner_req && !bus.mem_ready_in && (cnt_q == CNT_LAST);
        done   = (state_q != ST_IDLE) && owner_req && (bus.mem_ready_in || wd_hit);
    end

    always_comb begin
        bus.mem_address_out     = '0;
        bus.mem_read_out        = 1'b0;
        bus.mem_write_out       = 1'b0;
        bus.mem_write_mask_out  = '0;
        bus.mem_write_value_out = '0;
        bus.instr_ready_out     = 1'b0;
        bus.data_ready_out      = 1'b0;
        case (state_q)
            ST_INSTR: begin
                bus.mem_address_out = bus.instr_address_in;
                bus.mem_read_out    = bus.instr_read_in;
                bus.instr_ready_out = done;
            end
            ST_DATA: begin
                bus.mem_address_out     = bus.data_address_in;
                bus.mem_read_out        = bus.data_read_in;
                bus.mem_write_out       = bus.data_write_in;
                bus.mem_write_mask_out  = bus.data_write_mask_in;
                bus.mem_write_value_out = bus.data_write_value_in;
                bus.data_ready_out      = done;
            end
            default: ;
        endcase
        bus.instr_read_value_out = wd_hit ? 32'h0 : bus.mem_read_value_in;
        bus.data_read_value_out  = wd_hit ? 32'h0 : bus.mem_read_value_in;
        bus.timeout_out          = timeout_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (data_req)               state_d = ST_DATA;
                else if (bus.instr_read_in) state_d = ST_INSTR;
            end
            ST_INSTR: begin
                // The finished owner is never re-granted directly; that is what alternates.
                if (done)                    state_d = data_req ? ST_DATA : ST_IDLE;
                else if (!bus.instr_read_in) state_d = ST_IDLE;
            end
            ST_DATA: begin
                if (done)           state_d = bus.instr_read_in ? ST_INSTR : ST_IDLE;
                else if (!data_req) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        cnt_d = cnt_q;
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            cnt_d = '0;
        end else if (!bus.mem_ready_in && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        timeout_d = timeout_q | wd_hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Bench for rv32_bus_arbiter: directed scenarios plus random core/memory traffic,
// all checked cycle by cycle against a transfer-level reference model.
module tb_rv32_bus_arbiter;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        ir, dr, dw, mr;
    logic [31:0] ia, da, dv, mv;
    logic [3:0]  dm;

    rv32_bus_arbiter_if bus();

    assign bus.instr_address_in    = ia;
    assign bus.instr_read_in       = ir;
    assign bus.data_address_in     = da;
    assign bus.data_read_in        = dr;
    assign bus.data_write_in       = dw;
    assign bus.data_write_mask_in  = dm;
    assign bus.data_write_value_in = dv;
    assign bus.mem_read_value_in   = mv;
    assign bus.mem_ready_in        = mr;

    rv32_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference: owner 0 = nobody, 1 = fetch, 2 = load/store; waited = granted cycles so far.
    int m_owner, m_wait, n_owner, n_wait;
    bit m_to, n_to;
    bit e_irdy, e_drdy;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_eval();
        bit dreq, oreq, tnow, done;
        logic [31:0] e_addr, e_wv, e_rv;
        logic        e_rd, e_wr;
        logic [3:0]  e_mask;
        dreq = dr | dw;
        oreq = (m_owner == 1) ? ir : (m_owner == 2) ? dreq : 1'b0;
        tnow = (TO > 0) && (m_owner != 0) && oreq && !mr && (m_wait == TO - 1);
        done = (m_owner != 0) && oreq && (mr || tnow);
        e_addr = '0; e_wv = '0; e_rd = 1'b0; e_wr = 1'b0; e_mask = '0;
        if (m_owner == 1) begin
            e_addr = ia; e_rd = ir;
        end else if (m_owner == 2) begin
            e_addr = da; e_rd = dr; e_wr = dw; e_mask = dm; e_wv = dv;
        end
        e_irdy = done && (m_owner == 1);
        e_drdy = done && (m_owner == 2);
        e_rv   = tnow ? 32'h0 : mv;
        check_val("mem_address", bus.mem_address_out, e_addr);
        check_val("mem_read", bus.mem_read_out, e_rd);
        check_val("mem_write", bus.mem_write_out, e_wr);
        check_val("mem_mask", bus.mem_write_mask_out, e_mask);
        check_val("mem_wvalue", bus.mem_write_value_out, e_wv);
        check_val("instr_ready", bus.instr_ready_out, e_irdy);
        check_val("data_ready", bus.data_ready_out, e_drdy);
        if (e_irdy) check_val("instr_rvalue", bus.instr_read_value_out, e_rv);
        if (e_drdy) check_val("data_rvalue", bus.data_read_value_out, e_rv);
        check_val("timeout", bus.timeout_out, m_to);

        n_to    = m_to | tnow;
        n_owner = m_owner;
        n_wait  = m_wait + 1;
        if (m_owner == 0) begin
            n_owner = dreq ? 2 : (ir ? 1 : 0);
            n_wait  = 0;
        end else if (done) begin
            n_owner = (m_owner == 1) ? (dreq ? 2 : 0) : (ir ? 1 : 0);
            n_wait  = 0;
        end else if (!oreq) begin
            n_owner = 0;
            n_wait  = 0;
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_wait = 0; m_to = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else begin
            m_owner = n_owner; m_wait = n_wait; m_to = n_to;
        end
        #1;
    endtask

    task automatic quiet_inputs();
        ir = 0; dr = 0; dw = 0; mr = 0;
        ia = '0; da = '0; dv = '0; dm = '0; mv = '0;
    endtask

    initial begin
        quiet_inputs();
        model_reset();
        rst = 1'b1;
        mr  = 1'b1;
        mv  = 32'h1111_2222;
        repeat (2) begin
            settle();
            check_val("rst_mem_read", bus.mem_read_out, 0);
            check_val("rst_timeout", bus.timeout_out, 0);
            tick();
        end
        rst = 1'b0;
        mr  = 1'b0;

        // 1: lone fetch
        ir = 1; ia = 32'h100;
        settle(); check_val("t1_arb_cycle_read", bus.mem_read_out, 0); tick();
        settle(); check_val("t1_granted_read", bus.mem_read_out, 1);
        check_val("t1_granted_addr", bus.mem_address_out, 32'h100); tick();
        mr = 1; mv = 32'h1234_5678;
        settle(); check_val("t1_ready", bus.instr_ready_out, 1);
        check_val("t1_value", bus.instr_read_value_out, 32'h1234_5678); tick();
        ir = 0; mr = 0;
        settle(); tick();

        // 2: simultaneous fetch and store, data wins and fetch follows without an IDLE gap
        ir = 1; ia = 32'h200;
        dw = 1; da = 32'h80; dm = 4'b0011; dv = 32'hDEAD_BEEF;
        settle(); tick();
        settle();
        check_val("t2_write", bus.mem_write_out, 1);
        check_val("t2_mask", bus.mem_write_mask_out, 4'b0011);
        check_val("t2_wvalue", bus.mem_write_value_out, 32'hDEAD_BEEF);
        check_val("t2_addr", bus.mem_address_out, 32'h80);
        tick();
        mr = 1;
        settle(); check_val("t2_data_ready", bus.data_ready_out, 1); tick();
        dw = 0; mr = 0;
        settle(); check_val("t2_instr_next", bus.mem_read_out, 1);
        check_val("t2_instr_addr", bus.mem_address_out, 32'h200); tick();
        mr = 1; mv = 32'h0BAD_F00D;
        settle(); check_val("t2_instr_ready", bus.instr_ready_out, 1); tick();
        ir = 0; mr = 0;
        settle(); tick();

        // 3: both held, memory always ready: D,I,D,I...
        ir = 1; ia = 32'hA00; dr = 1; da = 32'hB00; mr = 1;
        settle(); tick();
        for (int k = 0; k < 10; k++) begin
            mv = $urandom;
            settle();
            check_val("t3_data_turn", bus.data_ready_out, (k % 2) == 0);
            check_val("t3_instr_turn", bus.instr_ready_out, (k % 2) == 1);
            tick();
        end
        ir = 0; dr = 0; mr = 0;
        repeat (2) begin settle(); tick(); end

        // 6: fetch aborted, then a pending load is granted
        ir = 1; ia = 32'h300;
        settle(); tick();
        settle(); check_val("t6_granted", bus.mem_read_out, 1); tick();
        ir = 0; dr = 1; da = 32'h400;
        settle(); check_val("t6_no_ready", bus.instr_ready_out, 0);
        check_val("t6_strobe_drop", bus.mem_read_out, 0); tick();
        settle(); check_val("t6_idle", bus.mem_read_out, 0); tick();
        mr = 1; mv = 32'h4444_0000;
        settle(); check_val("t6_load_addr", bus.mem_address_out, 32'h400);
        check_val("t6_load_ready", bus.data_ready_out, 1); tick();
        dr = 0; mr = 0;
        settle(); tick();

        // 5: async reset while a fetch waits on memory
        ir = 1; ia = 32'h500;
        settle(); tick();
        settle(); check_val("t5_granted", bus.mem_read_out, 1);
        #2 rst = 1'b1;
        #1;
        check_val("t5_rst_read", bus.mem_read_out, 0);
        check_val("t5_rst_addr", bus.mem_address_out, 0);
        check_val("t5_rst_ready", bus.instr_ready_out, 0);
        model_reset();
        ir = 0; mr = 1;
        tick();
        rst = 1'b0;
        repeat (3) begin
            settle(); check_val("t5_no_ready", bus.instr_ready_out, 0); tick();
        end
        mr = 0;

        // 4: watchdog on a load that memory never answers
        dr = 1; da = 32'h600; mv = 32'hCAFE_F00D;
        settle(); tick();
        for (int g = 1; g <= 4; g++) begin
            settle();
            check_val("t4_ready", bus.data_ready_out, g == 4);
            if (g == 4) check_val("t4_forced_zero", bus.data_read_value_out, 0);
            tick();
        end
        dr = 0;
        repeat (3) begin
            settle(); check_val("t4_sticky", bus.timeout_out, 1); tick();
        end

        // random traffic
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (!ir) begin
                if ($urandom_range(0, 2) == 0) begin ir = 1; ia = $urandom & 32'hFFFF_FFFC; end
            end else if ($urandom_range(0, 19) == 0) ir = 0;
            if (!(dr | dw)) begin
                if ($urandom_range(0, 2) == 0) begin
                    int r;
                    r  = $urandom_range(0, 7);
                    dr = (r < 4) || (r == 7);
                    dw = (r >= 4);
                    da = $urandom & 32'hFFFF_FFFC;
                    dm = 4'($urandom);
                    dv = $urandom;
                end
            end else if ($urandom_range(0, 19) == 0) begin
                dr = 0; dw = 0;
            end
            mr = ($urandom_range(0, 2) == 0);
            mv = $urandom;
            settle();
            tick();
            if (e_irdy) ir = 0;
            if (e_drdy) begin dr = 0; dw = 0; end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
